// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler
//   Shares the register file's single write port between the ALU writeback
//   path and the load-data path. It also tracks in-flight writes in a
//   per-register scoreboard and stalls decode issue on RAW/WAW hazards.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   alu_valid_i/rd_i/wd_i  ALU writeback request; alu_ready_o = accepted
//   mem_valid_i/rd_i/wd_i  load writeback request; mem_ready_o = accepted
//   iss_valid_i            decode is issuing an instruction this cycle
//   iss_rs_i, iss_rt_i     sources of the issuing instruction
//   iss_rd_i, iss_wr_i     destination of the issuing instruction, and whether it writes
//   stall_o                issue must hold (combinational)
//   rf_reg_write_o         registered register file write strobe
//   rf_rd_o, rf_wd_o       registered register file write address and data
//   pending_o              scoreboard bitmap (bit n = write to rn in flight)

module rf_write_scheduler #(
    parameter int DW = 32,
    parameter int AW = 5,
    localparam int NR = 2 ** AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          alu_valid_i,
    input  logic [AW-1:0] alu_rd_i,
    input  logic [DW-1:0] alu_wd_i,
    output logic          alu_ready_o,
    input  logic          mem_valid_i,
    input  logic [AW-1:0] mem_rd_i,
    input  logic [DW-1:0] mem_wd_i,
    output logic          mem_ready_o,
    input  logic          iss_valid_i,
    input  logic [AW-1:0] iss_rs_i,
    input  logic [AW-1:0] iss_rt_i,
    input  logic [AW-1:0] iss_rd_i,
    input  logic          iss_wr_i,
    output logic          stall_o,
    output logic          rf_reg_write_o,
    output logic [AW-1:0] rf_rd_o,
    output logic [DW-1:0] rf_wd_o,
    output logic [NR-1:0] pending_o
);

    typedef enum logic {
        PRIO_MEM = 1'b0,
        PRIO_ALU = 1'b1
    } prio_e;

    prio_e         prio_q, prio_d;
    logic          rf_reg_write_q, rf_reg_write_d;
    logic [AW-1:0] rf_rd_q, rf_rd_d;
    logic [DW-1:0] rf_wd_q, rf_wd_d;
    logic [NR-1:0] pending_q, pending_d;

    logic          grant_alu;
    logic          grant_mem;
    logic          any_grant;
    logic [AW-1:0] sel_rd;
    logic [DW-1:0] sel_wd;
    logic          haz_rs;
    logic          haz_rt;
    logic          haz_rd;
    logic          issue_set;

    // Arbitration: a lone requester always wins; on contention prio decides
    // and flips so the two sources alternate. Grants are masked during reset.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        prio_d    = prio_q;
        if (!rst_i) begin
            grant_mem = mem_valid_i && (!alu_valid_i || (prio_q == PRIO_MEM));
            grant_alu = alu_valid_i && (!mem_valid_i || (prio_q == PRIO_ALU));
            if (alu_valid_i && mem_valid_i) begin
                prio_d = (prio_q == PRIO_MEM) ? PRIO_ALU : PRIO_MEM;
            end
        end
    end

    assign any_grant = grant_alu || grant_mem;
    assign sel_rd    = grant_mem ? mem_rd_i : alu_rd_i;
    assign sel_wd    = grant_mem ? mem_wd_i : alu_wd_i;

    // Write stage: a grant to r0 is consumed but never produces a strobe.
    always_comb begin
        rf_reg_write_d = 1'b0;
        rf_rd_d        = rf_rd_q;
        rf_wd_d        = rf_wd_q;
        if (any_grant) begin
            rf_reg_write_d = (sel_rd != '0);
            rf_rd_d        = sel_rd;
            rf_wd_d        = sel_wd;
        end
    end

    // Hazard detection against the registered scoreboard. The clear lands at
    // the edge ending the commit cycle, so the register file already holds the
    // new value when the bit drops and no forwarding is needed.
    assign haz_rs  = (iss_rs_i != '0) && pending_q[iss_rs_i];
    assign haz_rt  = (iss_rt_i != '0) && pending_q[iss_rt_i];
    assign haz_rd  = iss_wr_i && (iss_rd_i != '0) && pending_q[iss_rd_i];
    assign stall_o = iss_valid_i && (haz_rs || haz_rt || haz_rd);

    assign issue_set = iss_valid_i && !stall_o && iss_wr_i && (iss_rd_i != '0);

    // The set is applied after the clear so a new writer of the register
    // being committed keeps its bit.
    always_comb begin
        pending_d = pending_q;
        if (rf_reg_write_q) begin
            pending_d[rf_rd_q] = 1'b0;
        end
        if (issue_set) begin
            pending_d[iss_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q         <= PRIO_MEM;
            rf_reg_write_q <= 1'b0;
            rf_rd_q        <= '0;
            rf_wd_q        <= '0;
            pending_q      <= '0;
        end else begin
            prio_q         <= prio_d;
            rf_reg_write_q <= rf_reg_write_d;
            rf_rd_q        <= rf_rd_d;
            rf_wd_q        <= rf_wd_d;
            pending_q      <= pending_d;
        end
    end

    assign alu_ready_o    = grant_alu;
    assign mem_ready_o    = grant_mem;
    assign rf_reg_write_o = rf_reg_write_q;
    assign rf_rd_o        = rf_rd_q;
    assign rf_wd_o        = rf_wd_q;
    assign pending_o      = pending_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb_rf_write_scheduler
//   Directed vectors with hand-computed expectations for rf_write_scheduler.
//   Inputs change at the falling edge; combinational outputs are sampled 1 ns
//   later, registered outputs 1 ns after the rising edge.

module tb_rf_write_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_rd_i = '0;
    logic [31:0] alu_wd_i = '0;
    logic        alu_ready_o;
    logic        mem_valid_i = 1'b0;
    logic [4:0]  mem_rd_i = '0;
    logic [31:0] mem_wd_i = '0;
    logic        mem_ready_o;
    logic        iss_valid_i = 1'b0;
    logic [4:0]  iss_rs_i = '0;
    logic [4:0]  iss_rt_i = '0;
    logic [4:0]  iss_rd_i = '0;
    logic        iss_wr_i = 1'b0;
    logic        stall_o;
    logic        rf_reg_write_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_wd_o;
    logic [31:0] pending_o;

    int n_tests = 0;
    int n_fail  = 0;

    rf_write_scheduler #(.DW(32), .AW(5)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .alu_valid_i    (alu_valid_i),
        .alu_rd_i       (alu_rd_i),
        .alu_wd_i       (alu_wd_i),
        .alu_ready_o    (alu_ready_o),
        .mem_valid_i    (mem_valid_i),
        .mem_rd_i       (mem_rd_i),
        .mem_wd_i       (mem_wd_i),
        .mem_ready_o    (mem_ready_o),
        .iss_valid_i    (iss_valid_i),
        .iss_rs_i       (iss_rs_i),
        .iss_rt_i       (iss_rt_i),
        .iss_rd_i       (iss_rd_i),
        .iss_wr_i       (iss_wr_i),
        .stall_o        (stall_o),
        .rf_reg_write_o (rf_reg_write_o),
        .rf_rd_o        (rf_rd_o),
        .rf_wd_o        (rf_wd_o),
        .pending_o      (pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic after_rise();
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_fall();
        @(negedge clk_i);
    endtask

    // Contention sequence: mem rd 1..4 queued, alu rd 9 re-requested each time.
    logic [4:0]  exp_order [4] = '{5'd1, 5'd9, 5'd2, 5'd9};
    logic        exp_mem   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [4:0] mem_next;

        // Reset state, with both sources requesting: no grant while in reset.
        alu_valid_i = 1'b1;
        mem_valid_i = 1'b1;
        #2;
        check("rst_alu_ready", alu_ready_o, 0);
        check("rst_mem_ready", mem_ready_o, 0);
        check("rst_reg_write", rf_reg_write_o, 0);
        check("rst_rd", rf_rd_o, 0);
        check("rst_wd", rf_wd_o, 0);
        check("rst_pending", pending_o, 0);

        at_fall();
        rst_i = 1'b0;
        alu_valid_i = 1'b0;
        mem_valid_i = 1'b0;

        // Single ALU write.
        at_fall();
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_wd_i = 32'hDEADBEEF;
        #1;
        check("t1_alu_ready", alu_ready_o, 1);
        check("t1_mem_ready", mem_ready_o, 0);
        after_rise();
        check("t1_we", rf_reg_write_o, 1);
        check("t1_rd", rf_rd_o, 5);
        check("t1_wd", rf_wd_o, 32'hDEADBEEF);
        at_fall();
        alu_valid_i = 1'b0;
        after_rise();
        check("t1_we_off", rf_reg_write_o, 0);
        check("t1_pending", pending_o, 0);

        // Contention: grants alternate starting with MEM.
        mem_next = 5'd1;
        for (int i = 0; i < 4; i++) begin
            at_fall();
            mem_valid_i = 1'b1; mem_rd_i = mem_next; mem_wd_i = 32'h100 + 32'(mem_next);
            alu_valid_i = 1'b1; alu_rd_i = 5'd9;     alu_wd_i = 32'hA1;
            #1;
            check($sformatf("t2_mem_ready%0d", i), mem_ready_o, exp_mem[i]);
            check($sformatf("t2_alu_ready%0d", i), alu_ready_o, !exp_mem[i]);
            after_rise();
            if (exp_mem[i]) mem_next = mem_next + 5'd1;
            check($sformatf("t2_we%0d", i), rf_reg_write_o, 1);
            check($sformatf("t2_rd%0d", i), rf_rd_o, exp_order[i]);
            check($sformatf("t2_wd%0d", i), rf_wd_o,
                  exp_mem[i] ? 32'h100 + 32'(exp_order[i]) : 32'hA1);
        end
        at_fall();
        mem_valid_i = 1'b0;
        alu_valid_i = 1'b0;

        // RAW on r7, resolved by an ALU write to r7.
        at_fall();
        iss_valid_i = 1'b1; iss_rd_i = 5'd7; iss_wr_i = 1'b1; iss_rs_i = 5'd0; iss_rt_i = 5'd0;
        #1;
        check("t3_issue_nostall", stall_o, 0);
        after_rise();
        check("t3_pending7", pending_o, 32'h80);
        at_fall();
        iss_rs_i = 5'd7; iss_rd_i = 5'd0; iss_wr_i = 1'b0;
        alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_wd_i = 32'h77;
        #1;
        check("t3_raw_stall", stall_o, 1);
        check("t3_alu_ready", alu_ready_o, 1);
        at_fall();
        alu_valid_i = 1'b0;
        #1;
        check("t3_commit_we", rf_reg_write_o, 1);
        check("t3_commit_rd", rf_rd_o, 7);
        check("t3_stall_commit", stall_o, 1);
        at_fall();
        #1;
        check("t3_stall_drop", stall_o, 0);
        check("t3_pending_clr", pending_o, 0);

        // WAW on r3, and zero sources never stall.
        at_fall();
        iss_rs_i = 5'd0; iss_rt_i = 5'd0; iss_rd_i = 5'd3; iss_wr_i = 1'b1;
        #1;
        check("t4_set_nostall", stall_o, 0);
        after_rise();
        check("t4_pending3", pending_o, 32'h8);
        at_fall();
        #1;
        check("t4_waw_stall", stall_o, 1);
        iss_wr_i = 1'b0;
        #1;
        check("t4_zero_src", stall_o, 0);
        iss_rt_i = 5'd3;
        #1;
        check("t4_rt_stall", stall_o, 1);
        iss_rt_i = 5'd0; iss_rd_i = 5'd0; iss_wr_i = 1'b1;
        #1;
        check("t4_rd0_nostall", stall_o, 0);
        after_rise();
        check("t4_no_r0_pending", pending_o, 32'h8);
        at_fall();
        iss_valid_i = 1'b0; iss_rs_i = 5'd3; iss_wr_i = 1'b0;
        #1;
        check("t4_no_valid", stall_o, 0);

        // Write to r0 is accepted and discarded.
        at_fall();
        iss_rs_i = 5'd0;
        mem_valid_i = 1'b1; mem_rd_i = 5'd0; mem_wd_i = 32'h1234;
        #1;
        check("t5_mem_ready", mem_ready_o, 1);
        after_rise();
        check("t5_no_we", rf_reg_write_o, 0);
        check("t5_pending", pending_o, 32'h8);
        at_fall();
        mem_valid_i = 1'b0;

        // Commit to non-pending r6 while a new writer of r6 issues: set wins.
        at_fall();
        alu_valid_i = 1'b1; alu_rd_i = 5'd6; alu_wd_i = 32'h66;
        at_fall();
        alu_valid_i = 1'b0;
        iss_valid_i = 1'b1; iss_rd_i = 5'd6; iss_wr_i = 1'b1;
        #1;
        check("t6_commit_we", rf_reg_write_o, 1);
        check("t6_commit_rd", rf_rd_o, 6);
        check("t6_nostall", stall_o, 0);
        after_rise();
        check("t6_set_wins", pending_o, 32'h48);

        // Reset during a commit with r5 pending.
        at_fall();
        iss_rd_i = 5'd5;
        after_rise();
        check("t7_pending5", pending_o, 32'h68);
        at_fall();
        iss_valid_i = 1'b0; iss_wr_i = 1'b0;
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_wd_i = 32'h55;
        after_rise();
        check("t7_we_before_rst", rf_reg_write_o, 1);
        rst_i = 1'b1;
        #1;
        check("t7_we_dropped", rf_reg_write_o, 0);
        check("t7_pending_clr", pending_o, 0);
        check("t7_alu_ready_rst", alu_ready_o, 0);
        at_fall();
        rst_i = 1'b0;
        alu_rd_i = 5'd10; alu_wd_i = 32'hAA;
        mem_valid_i = 1'b1; mem_rd_i = 5'd11; mem_wd_i = 32'hBB;
        #1;
        check("t7_mem_first", mem_ready_o, 1);
        check("t7_alu_waits", alu_ready_o, 0);
        after_rise();
        check("t7_rd", rf_rd_o, 11);
        at_fall();
        mem_valid_i = 1'b0;
        #1;
        check("t7_alu_next", alu_ready_o, 1);
        at_fall();
        alu_valid_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
Schedules the register file's single write port between two writeback sources: the ALU result path and the load-data path. It also keeps a 32-entry pending-write scoreboard that stalls issue while a source or destination register still has a write in flight. It sits between the EX/WB stage logic and the register file's write port (reg_write, rd, wd). Issue logic in the decode stage consumes its stall output.

Parameters:
DW, 32, data width of write data
AW, 5, register address width (2**AW registers; register 0 hardwired zero)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-high reset
alu_valid  input  1  ALU writeback request
alu_rd  input  AW  ALU destination register
alu_wd  input  DW  ALU writeback data
alu_ready  output  1  ALU request accepted this cycle
mem_valid  input  1  load writeback request
mem_rd  input  AW  load destination register
mem_wd  input  DW  load writeback data
mem_ready  output  1  load request accepted this cycle
iss_valid  input  1  decode issuing an instruction this cycle
iss_rs  input  AW  issuing instruction source 1
iss_rt  input  AW  issuing instruction source 2
iss_rd  input  AW  issuing instruction destination
iss_wr  input  1  issuing instruction writes iss_rd
stall  output  1  issue must hold; combinational
rf_reg_write  output  1  to register file reg_write; registered
rf_rd  output  AW  to register file rd; registered
rf_wd  output  DW  to register file wd; registered
pending  output  2**AW  scoreboard bitmap, for debug and verification

Behaviour:
- Reset (async, rst=1): rf_reg_write=0, rf_rd=0, rf_wd=0, pending=0, priority pointer prio=MEM. alu_ready and mem_ready are 0 while rst is high.
- Arbitration (combinational, one grant per cycle):
  - Only one source valid: that source is granted; prio unchanged.
  - Both valid: the source named by prio is granted; prio toggles to the other source at the clock edge.
  - alu_ready = grant_alu; mem_ready = grant_mem. A source holds valid, rd and wd stable until it sees ready.
- Write stage: at the edge where a grant occurs, rf_rd and rf_wd capture the granted rd/wd. rf_reg_write is set to 1 if granted rd != 0, otherwise 0.
  - With no grant, rf_reg_write=0; rf_rd and rf_wd hold their values.
  - Latency: request accepted in cycle N; rf_reg_write is high in cycle N+1; the register file commits at the end of N+1.
- A granted request with rd=0 is accepted and discarded: no write, no scoreboard change.
- Scoreboard:
  - Set: pending[iss_rd] is set at the edge where iss_valid=1, stall=0, iss_wr=1 and iss_rd != 0.
  - Clear: pending[rf_rd] is cleared at the edge ending a cycle with rf_reg_write=1. The reader sees the new value from the next cycle on, so no forwarding is needed.
  - A commit to a non-pending register still writes; pending stays 0.
  - Set and clear of the same index on the same edge: set wins.
- stall = iss_valid and any of:
  - iss_rs != 0 and pending[iss_rs]
  - iss_rt != 0 and pending[iss_rt]
  - iss_wr and iss_rd != 0 and pending[iss_rd] (WAW)
- pending[0] is always 0.
- Reset mid-operation: the in-flight write is dropped (rf_reg_write forced 0 immediately); the scoreboard is cleared.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_wd=0xDEADBEEF for one cycle -> alu_ready=1 that cycle; next cycle rf_reg_write=1, rf_rd=5, rf_wd=0xDEADBEEF; then rf_reg_write=0.
- Both valid for 4 cycles (mem rd 1..4, alu rd 9 held) -> grants in order MEM, ALU, MEM, ALU; each loser's ready stays 0 until its turn; writes appear one per cycle, order 1, 9, 2, 9.
- Issue iss_rd=7, iss_wr=1, then issue iss_rs=7 -> pending[7]=1 and stall=1. ALU later writes rd=7 -> stall drops the cycle after rf_reg_write=1 with rf_rd=7.
- WAW: pending[3]=1, issue iss_rd=3, iss_wr=1 -> stall=1. iss_rs=0 / iss_rt=0 with any pending bits -> stall=0.
- mem_valid=1, mem_rd=0, mem_wd=0x1234 -> mem_ready=1; rf_reg_write stays 0; pending unchanged.
- Assert rst in the cycle rf_reg_write=1 with pending[5]=1 -> rf_reg_write=0 immediately and pending=0. After release, prio=MEM: a simultaneous request is granted to mem first.
